ccc_reconfig_ctrl: RTL and testbench
====================================

CCC_RECONFIG_CTRL -- requirements
Module: ccc_reconfig_ctrl

Interface
REQ-001 Parameter NUM_BYTES, default 27, number of CCC configuration bytes written per sequence (1..64).
REQ-002 Parameter LOCK_TIMEOUT, default 4095, maximum cycles to wait for LOCK after PLL reset release.
REQ-003 Parameter LOCK_STABLE, default 16, consecutive LOCK-high cycles required to declare lock.
REQ-004 PCLK  in  1  single clock; all logic on rising edge.
REQ-005 PRESET  in  1  synchronous, active-high reset.
REQ-006 START  in  1  request to run one reconfiguration sequence.
REQ-007 TBL_IDX  out  6  index into the external configuration byte table.
REQ-008 TBL_DATA  in  8  table byte for TBL_IDX, combinational and valid in the same cycle.
REQ-009 PSEL, PENABLE, PWRITE  out  1 each  APB master controls to the CCC configuration port.
REQ-010 PADDR  out  6  APB address; PWDATA out 8  APB write data; PRDATA in 8  APB read data.
REQ-011 CCC_BUSY  in  1  CCC configuration-port busy, which extends the APB access phase.
REQ-012 PLL_ARST_N  out  1  PLL asynchronous reset, active-low.
REQ-013 LOCK  in  1  PLL lock from the CCC.
REQ-014 BUSY  out  1; DONE out 1 (one-cycle pulse); STATUS out 2 (00 ok, 01 lock timeout, 10 readback mismatch).

Function
REQ-015 The state machine SHALL have these states: IDLE, PLL_RST, SETUP, ACCESS, RELEASE, WAIT_LOCK, FINISH.
REQ-016 IDLE: START=1 SHALL move the machine to PLL_RST, clear STATUS to 00 and clear the index to 0; START SHALL be ignored in every other state.
REQ-017 PLL_RST: the block SHALL drive PLL_ARST_N=0 for exactly 1 cycle, then go to SETUP. PLL_ARST_N SHALL stay 0 until RELEASE.
REQ-018 SETUP: the block SHALL drive PSEL=1, PENABLE=0, PWRITE=1, PADDR=idx and PWDATA=TBL_DATA, then go to ACCESS.
REQ-019 ACCESS: the block SHALL drive PSEL=1 and PENABLE=1 and hold PADDR and PWDATA stable. The transfer completes on the first cycle with CCC_BUSY=0.
REQ-020 On completion, if idx<NUM_BYTES-1, idx SHALL increment and the machine SHALL return to SETUP; otherwise it SHALL go to RELEASE.
REQ-021 Each byte SHALL take exactly 2 cycles when CCC_BUSY=0 and 2+N cycles for N busy cycles. There SHALL be no idle cycle between bytes.
REQ-022 TBL_IDX SHALL equal idx at all times.
REQ-023 RELEASE: the block SHALL drive PLL_ARST_N=1 and clear the timeout and stable counters, then go to WAIT_LOCK.
REQ-024 WAIT_LOCK: the stable counter SHALL increment while LOCK=1 and reset to 0 when LOCK=0.
REQ-025 WAIT_LOCK: when the stable counter reaches LOCK_STABLE, the machine SHALL go to FINISH with STATUS=00.
REQ-026 WAIT_LOCK: the timeout counter SHALL increment every cycle. When it reaches LOCK_TIMEOUT without lock, STATUS SHALL become 01 and the machine SHALL go to FINISH.
REQ-027 If lock and timeout occur in the same cycle, lock SHALL win.
REQ-028 FINISH: DONE=1 for exactly 1 cycle, then the machine SHALL return to IDLE. STATUS SHALL hold until the next accepted START or reset.
REQ-029 BUSY=1 in every state except IDLE.
REQ-030 PSEL and PENABLE SHALL be 0 outside SETUP/ACCESS (and the readback states). PWRITE SHALL be 0 whenever PSEL=0.
REQ-031 The counters SHALL be sized to hold their parameter value and SHALL saturate, never wrap.

Reset
REQ-032 PRESET=1 SHALL force IDLE from any state within one cycle, including mid-APB-transfer.
REQ-033 Reset values SHALL be: PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, TBL_IDX=0, PLL_ARST_N=1, BUSY=0, DONE=0, STATUS=00.
REQ-034 Reset during PLL_RST or SETUP/ACCESS SHALL release PLL_ARST_N to 1 on the next edge. The partial CCC configuration SHALL be left as written.

Configuration
REQ-035 Macro CCC_RECONFIG_READBACK_EN: when defined, each completed write SHALL be followed by a 2-cycle APB read of the same address (RSETUP, RACCESS, PWRITE=0, extended by CCC_BUSY).
REQ-036 With CCC_RECONFIG_READBACK_EN defined: if PRDATA!=written byte, STATUS SHALL become 10 and the machine SHALL go to RELEASE, skipping the remaining bytes. A match SHALL continue normally.
REQ-037 Without the macro, the RSETUP and RACCESS states SHALL not exist and PRDATA SHALL be unused.

Verification
REQ-038 NUM_BYTES=4, CCC_BUSY=0, LOCK high from RELEASE+3 -> writes to PADDR 0,1,2,3 on consecutive 2-cycle transfers; DONE 1+8+1+3+16+1 cycles after START; STATUS=00.
REQ-039 CCC_BUSY=1 for 3 cycles during byte 2 -> ACCESS stretched to 4 cycles; PADDR=2 and PWDATA stable throughout; no byte skipped.
REQ-040 LOCK never asserts, LOCK_TIMEOUT=100 -> STATUS=01 and DONE exactly 101 cycles after RELEASE; PLL_ARST_N=1.
REQ-041 LOCK toggles 0/1 every 10 cycles, then stays high -> lock is declared only after 16 consecutive high cycles; START pulsed while BUSY=1 is ignored.
REQ-042 PRESET asserted during ACCESS of byte 1 -> next cycle all outputs at reset values; a new START restarts the sequence at idx 0.
REQ-043 Readback enabled, PRDATA=8'hFF versus written 8'h5A at byte 0 -> STATUS=10, no write to address 1, DONE asserted after lock.

Source files
------------

// File: rtl/ccc_reconfig_ctrl.sv
// CCC reconfiguration sequencer: holds the PLL in reset, streams table bytes over APB, then waits for lock.
// Optional APB readback-verify of every written byte is enabled by defining CCC_RECONFIG_READBACK_EN.
module ccc_reconfig_ctrl #(
  parameter int NUM_BYTES    = 27,
  parameter int LOCK_TIMEOUT = 4095,
  parameter int LOCK_STABLE  = 16
) (
  input  logic       PCLK,
  input  logic       PRESET,
  input  logic       START,
  output logic [5:0] TBL_IDX,
  input  logic [7:0] TBL_DATA,
  output logic       PSEL,
  output logic       PENABLE,
  output logic       PWRITE,
  output logic [5:0] PADDR,
  output logic [7:0] PWDATA,
  input  logic [7:0] PRDATA,
  input  logic       CCC_BUSY,
  output logic       PLL_ARST_N,
  input  logic       LOCK,
  output logic       BUSY,
  output logic       DONE,
  output logic [1:0] STATUS
);

  localparam int TW = $clog2(LOCK_TIMEOUT + 1);
  localparam int SW = $clog2(LOCK_STABLE + 1);
  localparam logic [TW-1:0] TMO_MAX  = TW'(LOCK_TIMEOUT);
  localparam logic [SW-1:0] STB_MAX  = SW'(LOCK_STABLE);
  localparam logic [5:0]    LAST_IDX = 6'(NUM_BYTES - 1);

`ifdef CCC_RECONFIG_READBACK_EN
  typedef enum logic [3:0] {
    ST_IDLE, ST_PLL_RST, ST_SETUP, ST_ACCESS, ST_RSETUP, ST_RACCESS,
    ST_RELEASE, ST_WAIT_LOCK, ST_FINISH
  } state_t;
`else
  typedef enum logic [2:0] {
    ST_IDLE, ST_PLL_RST, ST_SETUP, ST_ACCESS,
    ST_RELEASE, ST_WAIT_LOCK, ST_FINISH
  } state_t;
`endif

  state_t        r_state;
  state_t        w_state_next;
  logic [5:0]    r_idx;
  logic [5:0]    w_idx_next;
  logic [7:0]    r_wdata;
  logic [7:0]    w_wdata_next;
  logic [1:0]    r_status;
  logic [1:0]    w_status_next;
  logic [TW-1:0] r_tmo;
  logic [TW-1:0] w_tmo_next;
  logic [TW-1:0] w_tmo_inc;
  logic [SW-1:0] r_stable;
  logic [SW-1:0] w_stable_next;
  logic [SW-1:0] w_stable_inc;

`ifndef CCC_RECONFIG_READBACK_EN
  logic w_unused;
  assign w_unused = ^PRDATA;
`endif

  // Both counters saturate at their parameter value instead of wrapping.
  assign w_tmo_inc    = (r_tmo == TMO_MAX)    ? r_tmo    : r_tmo + TW'(1);
  assign w_stable_inc = (r_stable == STB_MAX) ? r_stable : r_stable + SW'(1);

  assign TBL_IDX = r_idx;
  assign PADDR   = r_idx;
  assign STATUS  = r_status;

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_state  <= ST_IDLE;
      r_idx    <= '0;
      r_wdata  <= '0;
      r_status <= 2'b00;
      r_tmo    <= '0;
      r_stable <= '0;
    end else begin
      r_state  <= w_state_next;
      r_idx    <= w_idx_next;
      r_wdata  <= w_wdata_next;
      r_status <= w_status_next;
      r_tmo    <= w_tmo_next;
      r_stable <= w_stable_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_idx_next    = r_idx;
    w_wdata_next  = r_wdata;
    w_status_next = r_status;
    w_tmo_next    = r_tmo;
    w_stable_next = r_stable;
    PSEL          = 1'b0;
    PENABLE       = 1'b0;
    PWRITE        = 1'b0;
    PWDATA        = 8'h00;
    PLL_ARST_N    = 1'b1;
    BUSY          = 1'b1;
    DONE          = 1'b0;

    case (r_state)
      ST_IDLE: begin
        BUSY = 1'b0;
        if (START) begin
          w_state_next  = ST_PLL_RST;
          w_status_next = 2'b00;
          w_idx_next    = '0;
        end
      end
      ST_PLL_RST: begin
        PLL_ARST_N   = 1'b0;
        w_state_next = ST_SETUP;
      end
      ST_SETUP: begin
        PLL_ARST_N   = 1'b0;
        PSEL         = 1'b1;
        PWRITE       = 1'b1;
        PWDATA       = TBL_DATA;
        w_wdata_next = TBL_DATA;
        w_state_next = ST_ACCESS;
      end
      // Captured byte keeps PWDATA stable however long CCC_BUSY stretches the access.
      ST_ACCESS: begin
        PLL_ARST_N = 1'b0;
        PSEL       = 1'b1;
        PENABLE    = 1'b1;
        PWRITE     = 1'b1;
        PWDATA     = r_wdata;
        if (!CCC_BUSY) begin
`ifdef CCC_RECONFIG_READBACK_EN
          w_state_next = ST_RSETUP;
`else
          if (r_idx != LAST_IDX) begin
            w_idx_next   = r_idx + 6'd1;
            w_state_next = ST_SETUP;
          end else begin
            w_state_next = ST_RELEASE;
          end
`endif
        end
      end
`ifdef CCC_RECONFIG_READBACK_EN
      ST_RSETUP: begin
        PLL_ARST_N   = 1'b0;
        PSEL         = 1'b1;
        PWDATA       = r_wdata;
        w_state_next = ST_RACCESS;
      end
      ST_RACCESS: begin
        PLL_ARST_N = 1'b0;
        PSEL       = 1'b1;
        PENABLE    = 1'b1;
        PWDATA     = r_wdata;
        if (!CCC_BUSY) begin
          if (PRDATA != r_wdata) begin
            w_status_next = 2'b10;
            w_state_next  = ST_RELEASE;
          end else if (r_idx != LAST_IDX) begin
            w_idx_next   = r_idx + 6'd1;
            w_state_next = ST_SETUP;
          end else begin
            w_state_next = ST_RELEASE;
          end
        end
      end
`endif
      ST_RELEASE: begin
        w_tmo_next    = '0;
        w_stable_next = '0;
        w_state_next  = ST_WAIT_LOCK;
      end
      // Lock is tested first so it wins a tie with the timeout; a recorded mismatch is kept.
      ST_WAIT_LOCK: begin
        w_tmo_next    = w_tmo_inc;
        w_stable_next = LOCK ? w_stable_inc : '0;
        if (LOCK && (w_stable_inc == STB_MAX)) begin
          w_state_next = ST_FINISH;
        end else if (w_tmo_inc == TMO_MAX) begin
          w_state_next = ST_FINISH;
          if (r_status == 2'b00) begin
            w_status_next = 2'b01;
          end
        end
      end
      ST_FINISH: begin
        DONE         = 1'b1;
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_ccc_reconfig_ctrl.sv
// Self-checking bench for ccc_reconfig_ctrl: a per-cycle expected timeline is built from the sequencing rules
// (byte schedule, lock run-length, timeout) and every cycle of every run is compared against it.
module tb_ccc_reconfig_ctrl;

  localparam int NB   = 4;
  localparam int TMO  = 100;
  localparam int STB  = 16;
  localparam int MAXC = 1024;

  logic       clk = 1'b0;
  logic       preset, start, ccc_busy, lock;
  logic [5:0] tbl_idx, paddr;
  logic [7:0] tbl_data, pwdata, prdata;
  logic       psel, penable, pwrite, pll_arst_n, busy, done;
  logic [1:0] status;

  always #5 clk = ~clk;

  typedef struct packed {
    logic       busy, done, arst, psel, pen, pwr;
    logic [5:0] idx;
    logic       chk_addr, chk_wdata;
    logic [7:0] wdata;
  } exp_t;

  exp_t       exp_a    [MAXC];
  logic       busy_drv [MAXC];
  logic       lock_drv [MAXC];
  logic [7:0] tbl      [64];
  int         stall    [64];
  logic       rb_bad   [64];
  logic       lock_pat [TMO];
  int         mc, fin_cyc;
  logic [1:0] exp_status;
  int         n_checks = 0;
  int         n_pass   = 0;

  assign tbl_data = tbl[tbl_idx];
`ifdef CCC_RECONFIG_READBACK_EN
  assign prdata = rb_bad[paddr] ? 8'hFF : tbl[paddr];
`else
  assign prdata = 8'h00;
`endif

  ccc_reconfig_ctrl #(.NUM_BYTES(NB), .LOCK_TIMEOUT(TMO), .LOCK_STABLE(STB)) dut (
    .PCLK(clk), .PRESET(preset), .START(start),
    .TBL_IDX(tbl_idx), .TBL_DATA(tbl_data),
    .PSEL(psel), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata),
    .CCC_BUSY(ccc_busy), .PLL_ARST_N(pll_arst_n), .LOCK(lock),
    .BUSY(busy), .DONE(done), .STATUS(status)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic check_reset(input string tag);
    check(tag, {psel, penable, pwrite, paddr, pwdata, tbl_idx, pll_arst_n, busy, done, status},
          {3'b000, 6'd0, 8'd0, 6'd0, 1'b1, 1'b0, 1'b0, 2'b00});
  endtask

  task automatic put(input logic b, input logic d, input logic a, input logic ps, input logic pe,
                     input logic pw, input logic [5:0] ix, input logic ca, input logic cw,
                     input logic [7:0] wd);
    exp_a[mc] = '{b, d, a, ps, pe, pw, ix, ca, cw, wd};
    mc++;
  endtask

  task automatic fill_tbl();
    for (int i = 0; i < 64; i++) begin
      tbl[i]    = 8'($urandom);
      stall[i]  = 0;
      rb_bad[i] = 1'b0;
    end
  endtask

  // Expected timeline, cycle 0 = the IDLE cycle in which START is presented.
  task automatic build_model();
    int run;
    int last;
    mc         = 1;
    exp_status = 2'b00;
    last       = NB - 1;
    for (int c = 0; c < MAXC; c++) begin
      busy_drv[c] = 1'($urandom);
      lock_drv[c] = 1'($urandom);
    end
    put(1, 0, 0, 0, 0, 0, 6'd0, 0, 0, 8'h00);
    for (int i = 0; i < NB; i++) begin
      put(1, 0, 0, 1, 0, 1, 6'(i), 1, 1, tbl[i]);
      for (int s = 0; s <= stall[i]; s++) begin
        busy_drv[mc] = (s < stall[i]);
        put(1, 0, 0, 1, 1, 1, 6'(i), 1, 1, tbl[i]);
      end
`ifdef CCC_RECONFIG_READBACK_EN
      put(1, 0, 0, 1, 0, 0, 6'(i), 1, 0, 8'h00);
      busy_drv[mc] = 1'b0;
      put(1, 0, 0, 1, 1, 0, 6'(i), 1, 0, 8'h00);
      if (rb_bad[i]) begin
        exp_status = 2'b10;
        last       = i;
        break;
      end
`endif
    end
    put(1, 0, 1, 0, 0, 0, 6'(last), 0, 0, 8'h00);
    run = 0;
    for (int k = 0; k < TMO; k++) begin
      lock_drv[mc] = lock_pat[k];
      put(1, 0, 1, 0, 0, 0, 6'(last), 0, 0, 8'h00);
      run = lock_pat[k] ? run + 1 : 0;
      if (run >= STB) break;
      if (k + 1 >= TMO && exp_status == 2'b00) exp_status = 2'b01;
    end
    fin_cyc = mc;
    put(1, 1, 1, 0, 0, 0, 6'(last), 0, 0, 8'h00);
    put(0, 0, 1, 0, 0, 0, 6'(last), 0, 0, 8'h00);
  endtask

  task automatic run_seq(input string tag);
    exp_t e;
    int   nwr;
    build_model();
    nwr = 0;
    @(posedge clk); #1;
    start    = 1'b1;
    ccc_busy = 1'($urandom);
    lock     = 1'($urandom);
    @(negedge clk);
    check({tag, " idle"}, {30'd0, busy, done}, 32'd0);
    for (int c = 1; c < mc; c++) begin
      @(posedge clk); #1;
      start    = (c < mc - 1) ? 1'($urandom) : 1'b0;
      ccc_busy = busy_drv[c];
      lock     = lock_drv[c];
      @(negedge clk);
      e = exp_a[c];
      check($sformatf("%s c%0d ctl", tag, c),
            {busy, done, pll_arst_n, psel, penable, pwrite, tbl_idx},
            {e.busy, e.done, e.arst, e.psel, e.pen, e.pwr, e.idx});
      if (e.chk_addr)  check($sformatf("%s c%0d paddr", tag, c), paddr, e.idx);
      if (e.chk_wdata) check($sformatf("%s c%0d pwdata", tag, c), pwdata, e.wdata);
      if (c == 1)        check($sformatf("%s status_clr", tag), status, 2'b00);
      if (c >= fin_cyc)  check($sformatf("%s c%0d status", tag, c), status, exp_status);
      if (psel && penable && pwrite && !ccc_busy) nwr++;
    end
    start = 1'b0;
    $display("run %-10s writes=%0d status=%b done_cycle=%0d", tag, nwr, status, fin_cyc);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic found;
    preset = 1'b1; start = 1'b0; ccc_busy = 1'b0; lock = 1'b0;
    fill_tbl();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset("reset_vals");
    @(posedge clk); #1;
    preset = 1'b0;

    // Ideal run: no busy, lock rises after 3 WAIT_LOCK cycles.
    fill_tbl();
    for (int k = 0; k < TMO; k++) lock_pat[k] = (k >= 3);
    run_seq("basic");

    fill_tbl();
    stall[2] = 3;
    run_seq("stall_b2");

    fill_tbl();
    for (int k = 0; k < TMO; k++) lock_pat[k] = 1'b0;
    run_seq("timeout");

    fill_tbl();
    for (int k = 0; k < TMO; k++) lock_pat[k] = (k < 60) ? (((k / 10) % 2) == 1) : 1'b1;
    run_seq("toggle");

    fill_tbl();
    for (int k = 0; k < TMO; k++) lock_pat[k] = (k >= TMO - STB);
    run_seq("lock_tie");

    fill_tbl();
    for (int k = 0; k < TMO; k++) lock_pat[k] = (k >= TMO - STB + 1);
    run_seq("lock_late");

    // Reset in the middle of byte 1's access phase.
    fill_tbl();
    @(posedge clk); #1;
    start = 1'b1; ccc_busy = 1'b0; lock = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    found = 1'b0;
    for (int w = 0; w < 20 && !found; w++) begin
      @(negedge clk);
      if (psel && penable && pwrite && paddr == 6'd1) found = 1'b1;
    end
    check("rst_reach_acc1", {31'd0, found}, 32'd1);
    preset   = 1'b1;
    ccc_busy = 1'b1;
    @(posedge clk); #1;
    preset = 1'b0;
    @(negedge clk);
    check_reset("rst_mid_access");

    for (int k = 0; k < TMO; k++) lock_pat[k] = (k >= 3);
    run_seq("restart");

    for (int r = 0; r < 6; r++) begin
      int onset;
      fill_tbl();
      for (int i = 0; i < NB; i++) stall[i] = int'($urandom_range(0, 3));
      onset = int'($urandom_range(0, 95));
      for (int k = 0; k < TMO; k++) lock_pat[k] = (k >= onset) || ($urandom_range(0, 3) == 0);
      run_seq($sformatf("rand%0d", r));
    end

`ifdef CCC_RECONFIG_READBACK_EN
    fill_tbl();
    tbl[0]    = 8'h5A;
    rb_bad[0] = 1'b1;
    for (int k = 0; k < TMO; k++) lock_pat[k] = (k >= 3);
    run_seq("rb_mismatch");
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
